calc_reg_bank: RTL and testbench
================================

Name: calc_reg_bank

Overview:
Parametrised HPS-to-fabric register bank for the hardware calculator. It holds operand and opcode registers written by the HPS, sequences one calculation per start command through a start/done handshake with a timeout, and captures the result and flags. It exposes a registered read port, sticky status bits and a level interrupt. It sits between the HPS bridge and the calculator datapath.

Parameters:
DATA_W, 16, width of every register and data bus (≥8).
ADDR_W, 4, register address width (≥3).
FLAG_W, 4, width of calculator flag vector (≤ DATA_W-4).
TIMEOUT, 1024, max cycles spent in WAIT before abort (≥2); counter width is $clog2(TIMEOUT+1).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
wr_en  in  1  HPS write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_en  in  1  HPS read strobe
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  registered read data
rd_valid  out  1  high one cycle after rd_en
op_a  out  DATA_W  operand A to datapath
op_b  out  DATA_W  operand B to datapath
op_code  out  DATA_W  opcode to datapath
calc_start  out  1  one-cycle start pulse
calc_done  in  1  datapath completion pulse
calc_result  in  DATA_W  result, valid with calc_done
calc_flags  in  FLAG_W  flags, valid with calc_done
irq  out  1  level interrupt = STATUS.done | STATUS.timeout | STATUS.err

Behaviour:
- Register map: 0 A (RW), 1 B (RW), 2 OPCODE (RW), 3 RESULT (RO), 4 STATUS (RO; W1C on bits 1-3), 5 CTRL (WO, reads 0; bit0 start, bit1 clear). All other addresses read 0; writes to them are ignored.
- STATUS layout: bit0 busy (state≠IDLE), bit1 done, bit2 timeout, bit3 err, bits[4+FLAG_W-1:4] last captured flags, rest 0.
- Reset (rst=0, async): all registers 0, FSM IDLE, calc_start=0, rd_valid=0, rd_data=0, irq=0.
- op_a/op_b/op_code drive directly from A/B/OPCODE.
- Read: rd_data and rd_valid update the cycle after rd_en. rd_data holds its value when rd_en=0. A read and a write to the same address in the same cycle returns the pre-write value.
- FSM states and transitions:
  - IDLE: on a CTRL write with bit0=1, go to START.
  - START: calc_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: increment the counter each cycle.
    - On calc_done: RESULT←calc_result, flags←calc_flags, set done, go to IDLE.
    - Otherwise, when the counter reaches TIMEOUT-1: set timeout, leave RESULT/flags unchanged, go to IDLE.
    - If calc_done and the timeout limit occur in the same cycle, done wins.
- Start-to-done latency seen by the HPS: busy rises the cycle after the CTRL write; done is set the cycle after calc_done.
- Busy rules:
  - Writes to A/B/OPCODE while busy are dropped and set err.
  - A CTRL start while busy is ignored and sets err.
  - calc_done in IDLE or START is ignored.
- CTRL bit1 clears done/timeout/err. If bit1 and bit0 are written together in IDLE, the clear applies and the new start proceeds.
- W1C on STATUS bits 1-3: a write of 1 clears the bit. If a hardware set and a W1C hit the same bit in the same cycle, the set wins.
- Starting a new operation does not auto-clear done/timeout/err.
- Reset mid-WAIT aborts immediately with no pulse and no capture. A calc_done arriving after reset release is ignored.

Test Plan:
- Write A=0x0003, B=0x0004, OPCODE=0x0001, CTRL=0x1; model returns calc_done 5 cycles after calc_start with result 0x0007, flags 0x2 → calc_start high exactly 1 cycle; read RESULT=0x0007; STATUS=0x0022; irq=1; write STATUS=0x0002 → STATUS=0x0020, irq=0.
- Start with the model never asserting done → timeout bit set exactly TIMEOUT cycles after calc_start; RESULT unchanged; busy=0; irq=1.
- During WAIT, write A=0xFFFF and CTRL=0x1 → A unchanged, no second calc_start, err=1; after done, STATUS bits 3 and 1 both set.
- calc_done on the same cycle the counter hits TIMEOUT-1 → done=1, timeout=0, RESULT captured. Separately, W1C of done on the same cycle as done being set → done remains 1.
- Read addr 7 → rd_data=0, rd_valid one cycle later. Read A while writing A=0x1234 in the same cycle → old value returned; next read returns 0x1234.
- Assert rst low mid-WAIT → all outputs 0 asynchronously; calc_done after release is ignored; STATUS=0.

Source files
------------

// File: rtl/calc_reg_bank.sv
// HPS-to-fabric register bank for the hardware calculator: operand/opcode registers,
// one-shot start/done sequencing with timeout, result capture, sticky status and irq.
module calc_reg_bank #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int FLAG_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] op_code,
    output logic              calc_start,
    input  logic              calc_done,
    input  logic [DATA_W-1:0] calc_result,
    input  logic [FLAG_W-1:0] calc_flags,
    output logic              irq
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The abort fires on the edge where the counter steps to TIMEOUT-1.
    localparam logic [CNT_W-1:0]  CNT_LIMIT   = CNT_W'(TIMEOUT - 2);
    localparam logic [ADDR_W-1:0] ADDR_A      = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_B      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_OPCODE = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_RESULT = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(5);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [DATA_W-1:0]  a_r, b_r, opcode_r, result_r, rd_data_r;
    logic [FLAG_W-1:0]  flags_r;
    logic               done_r, timeout_r, err_r;
    logic               calc_start_r, rd_valid_r, irq_r;

    logic               busy_s, ctrl_wr_s, stat_wr_s, reg_wr_s;
    logic               start_req_s, clr_req_s;
    logic               done_set_s, to_set_s, err_set_s;
    logic               done_nxt_s, to_nxt_s, err_nxt_s;
    logic [DATA_W-1:0]  status_s, rd_mux_s;

    // Decode of HPS writes and calculator events
    always_comb begin
        busy_s      = (state_r != ST_IDLE);
        ctrl_wr_s   = wr_en && (wr_addr == ADDR_CTRL);
        stat_wr_s   = wr_en && (wr_addr == ADDR_STATUS);
        reg_wr_s    = wr_en && ((wr_addr == ADDR_A) || (wr_addr == ADDR_B) ||
                                (wr_addr == ADDR_OPCODE));
        start_req_s = ctrl_wr_s && wr_data[0];
        clr_req_s   = ctrl_wr_s && wr_data[1];
        done_set_s  = (state_r == ST_WAIT) && calc_done;
        to_set_s    = (state_r == ST_WAIT) && !calc_done && (cnt_r == CNT_LIMIT);
        err_set_s   = busy_s && (reg_wr_s || start_req_s);
    end

    // Sticky flag next-state: hardware set beats any clear in the same cycle
    always_comb begin
        if (done_set_s) begin
            done_nxt_s = 1'b1;
        end else if (clr_req_s || (stat_wr_s && wr_data[1])) begin
            done_nxt_s = 1'b0;
        end else begin
            done_nxt_s = done_r;
        end
        if (to_set_s) begin
            to_nxt_s = 1'b1;
        end else if (clr_req_s || (stat_wr_s && wr_data[2])) begin
            to_nxt_s = 1'b0;
        end else begin
            to_nxt_s = timeout_r;
        end
        if (err_set_s) begin
            err_nxt_s = 1'b1;
        end else if (clr_req_s || (stat_wr_s && wr_data[3])) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Status word assembly and read mux (reads see pre-write state)
    always_comb begin
        status_s              = '0;
        status_s[0]           = busy_s;
        status_s[1]           = done_r;
        status_s[2]           = timeout_r;
        status_s[3]           = err_r;
        status_s[4 +: FLAG_W] = flags_r;
        case (rd_addr)
            ADDR_A:      rd_mux_s = a_r;
            ADDR_B:      rd_mux_s = b_r;
            ADDR_OPCODE: rd_mux_s = opcode_r;
            ADDR_RESULT: rd_mux_s = result_r;
            ADDR_STATUS: rd_mux_s = status_s;
            default:     rd_mux_s = '0;
        endcase
    end

    // Operand and opcode registers, writable only while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r      <= '0;
            b_r      <= '0;
            opcode_r <= '0;
        end else if (wr_en && !busy_s) begin
            if (wr_addr == ADDR_A) begin
                a_r <= wr_data;
            end else if (wr_addr == ADDR_B) begin
                b_r <= wr_data;
            end else if (wr_addr == ADDR_OPCODE) begin
                opcode_r <= wr_data;
            end else begin
                a_r <= a_r;
            end
        end else begin
            a_r <= a_r;
        end
    end

    // Calculation sequencer: start pulse, timeout counter, result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            calc_start_r <= 1'b0;
            result_r     <= '0;
            flags_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    calc_start_r <= 1'b0;
                    if (start_req_s) begin
                        state_r      <= ST_START;
                        calc_start_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    calc_start_r <= 1'b0;
                    cnt_r        <= '0;
                    state_r      <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (done_set_s) begin
                        result_r <= calc_result;
                        flags_r  <= calc_flags;
                        state_r  <= ST_IDLE;
                    end else if (to_set_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    calc_start_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky status bits and the interrupt derived from their next values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            err_r     <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            done_r    <= done_nxt_s;
            timeout_r <= to_nxt_s;
            err_r     <= err_nxt_s;
            irq_r     <= done_nxt_s | to_nxt_s | err_nxt_s;
        end
    end

    // Registered read port; data holds between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                rd_data_r <= rd_mux_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign op_a       = a_r;
    assign op_b       = b_r;
    assign op_code    = opcode_r;
    assign calc_start = calc_start_r;
    assign rd_data    = rd_data_r;
    assign rd_valid   = rd_valid_r;
    assign irq        = irq_r;

endmodule

// File: tb/tb_calc_reg_bank.sv
// Directed self-checking bench for calc_reg_bank; inputs driven and outputs sampled on the falling edge.
module tb_calc_reg_bank;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [15:0] op_a, op_b, op_code;
    logic        calc_start;
    logic        calc_done;
    logic [15:0] calc_result;
    logic [3:0]  calc_flags;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int starts;
    int k;

    calc_reg_bank #(.DATA_W(16), .ADDR_W(4), .FLAG_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .op_a(op_a), .op_b(op_b), .op_code(op_code),
        .calc_start(calc_start), .calc_done(calc_done),
        .calc_result(calc_result), .calc_flags(calc_flags), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        step();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
        step();
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        check(tag, {16'd0, rd_data}, {16'd0, exp});
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'd0;
        rd_en = 1'b0; rd_addr = 4'd0; calc_done = 1'b0;
        calc_result = 16'd0; calc_flags = 4'd0;
        step(); step();
        check("rst_rd_data", {16'd0, rd_data}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_calc_start", {31'd0, calc_start}, 32'd0);
        rst = 1'b1;
        chk_rd("rst_status", 4'd4, 16'h0000);

        // Basic calculation: done arrives 5 cycles after the start pulse
        wr(4'd0, 16'h0003); wr(4'd1, 16'h0004); wr(4'd2, 16'h0001);
        check("op_a", {16'd0, op_a}, 32'h0003);
        check("op_b", {16'd0, op_b}, 32'h0004);
        check("op_code", {16'd0, op_code}, 32'h0001);
        wr(4'd5, 16'h0001);
        check("start_pulse", {31'd0, calc_start}, 32'd1);
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (calc_start) starts++;
        end
        calc_done = 1'b1; calc_result = 16'h0007; calc_flags = 4'h2;
        step();
        calc_done = 1'b0;
        check("start_single_cycle", starts, 32'd0);
        check("irq_on_done", {31'd0, irq}, 32'd1);
        chk_rd("result_basic", 4'd3, 16'h0007);
        chk_rd("status_basic", 4'd4, 16'h0022);
        wr(4'd4, 16'h0002);
        chk_rd("status_w1c", 4'd4, 16'h0020);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);

        // Timeout: bit seen TO cycles after the cycle calc_start is high
        wr(4'd5, 16'h0001);
        check("to_start_pulse", {31'd0, calc_start}, 32'd1);
        k = 0;
        while (!irq && k < 100) begin
            step();
            k++;
        end
        check("timeout_latency", k, TO);
        chk_rd("to_result_kept", 4'd3, 16'h0007);
        chk_rd("to_status", 4'd4, 16'h0024);
        check("to_irq", {31'd0, irq}, 32'd1);
        wr(4'd5, 16'h0002);
        check("ctrl_clear_irq", {31'd0, irq}, 32'd0);
        chk_rd("ctrl_clear_status", 4'd4, 16'h0020);

        // Writes and a second start while busy are dropped and flag err
        wr(4'd5, 16'h0001);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        step();
        check("busy_no_restart0", {31'd0, calc_start}, 32'd0);
        wr_addr = 4'd5; wr_data = 16'h0001;
        step();
        wr_en = 1'b0;
        check("busy_no_restart1", {31'd0, calc_start}, 32'd0);
        check("busy_a_kept", {16'd0, op_a}, 32'h0003);
        check("busy_err_irq", {31'd0, irq}, 32'd1);
        calc_done = 1'b1; calc_result = 16'h0015; calc_flags = 4'h1;
        step();
        calc_done = 1'b0;
        check("busy_no_restart2", {31'd0, calc_start}, 32'd0);
        chk_rd("busy_status", 4'd4, 16'h001A);
        chk_rd("busy_result", 4'd3, 16'h0015);
        wr(4'd5, 16'h0002);

        // calc_done in the timeout-limit cycle: done wins
        wr(4'd5, 16'h0001);
        repeat (TO - 1) step();
        calc_done = 1'b1; calc_result = 16'hBEEF; calc_flags = 4'h5;
        step();
        calc_done = 1'b0;
        chk_rd("race_status", 4'd4, 16'h0052);
        chk_rd("race_result", 4'd3, 16'hBEEF);

        // W1C of done in the same cycle done is set: set wins
        wr(4'd5, 16'h0002);
        wr(4'd5, 16'h0001);
        step(); step();
        calc_done = 1'b1; calc_result = 16'h0042; calc_flags = 4'h3;
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0002;
        step();
        calc_done = 1'b0; wr_en = 1'b0;
        chk_rd("w1c_race_status", 4'd4, 16'h0032);

        // Read port: unmapped address, read/write collision, hold
        step();
        rd_en = 1'b1; rd_addr = 4'd7;
        step();
        rd_en = 1'b0;
        check("rd_unmapped", {16'd0, rd_data}, 32'd0);
        check("rd_valid_high", {31'd0, rd_valid}, 32'd1);
        step();
        check("rd_valid_low", {31'd0, rd_valid}, 32'd0);
        rd_en = 1'b1; rd_addr = 4'd0;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234;
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        check("rd_pre_write", {16'd0, rd_data}, 32'h0003);
        check("wr_same_cycle", {16'd0, op_a}, 32'h1234);
        chk_rd("rd_post_write", 4'd0, 16'h1234);
        step(); step();
        check("rd_hold", {16'd0, rd_data}, 32'h1234);
        chk_rd("rd_ctrl_zero", 4'd5, 16'h0000);
        chk_rd("rd_b", 4'd1, 16'h0004);
        chk_rd("rd_opcode", 4'd2, 16'h0001);

        // Asynchronous reset in the middle of WAIT
        wr(4'd5, 16'h0001);
        step();
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_op_a", {16'd0, op_a}, 32'd0);
        check("async_op_b", {16'd0, op_b}, 32'd0);
        check("async_op_code", {16'd0, op_code}, 32'd0);
        check("async_irq", {31'd0, irq}, 32'd0);
        check("async_rd_data", {16'd0, rd_data}, 32'd0);
        check("async_calc_start", {31'd0, calc_start}, 32'd0);
        step();
        rst = 1'b1;
        calc_done = 1'b1; calc_result = 16'hAAAA; calc_flags = 4'hF;
        step();
        calc_done = 1'b0;
        chk_rd("post_rst_status", 4'd4, 16'h0000);
        chk_rd("post_rst_result", 4'd3, 16'h0000);
        check("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
